// File: rtl/read_32_stream_source_pkg.sv
// Shared types and defaults for the 32-bit host-read stream source.
package read_stream_pkg;

    typedef enum logic [1:0] {IDLE, STREAM, DONE} st_e;

    localparam int unsigned PIX_MAX        = 255;
    localparam int unsigned DEPTH_LOG2_DEF = 9;
    localparam int unsigned LEN_W_DEF      = 16;

    // Signed result saturated to the 8-bit pixel range, zero-extended.
    function automatic logic [31:0] clamp_pix(input logic [31:0] v);
        if (v[31])
            return '0;
        else if (v > 32'(PIX_MAX))
            return 32'(PIX_MAX);
        else
            return v;
    endfunction

endpackage

// File: rtl/read_32_stream_source_if.sv
// Pipeline-result and Xillybus read-stream signals of read_32_stream_source.
interface read_32_stream_source_if
    import read_stream_pkg::*;
#(
    parameter int unsigned LEN_W = LEN_W_DEF
);
    logic             res_valid;
    logic [31:0]      res_data;
    logic             res_ready;
    logic [LEN_W-1:0] frame_len;
    logic             user_r_read_32_rden;
    logic             user_r_read_32_open;
    logic [31:0]      user_r_read_32_data;
    logic             user_r_read_32_empty;
    logic             user_r_read_32_eof;
    logic [LEN_W-1:0] words_sent;

    modport master (
        output res_valid, res_data, frame_len, user_r_read_32_rden, user_r_read_32_open,
        input  res_ready, user_r_read_32_data, user_r_read_32_empty, user_r_read_32_eof,
               words_sent
    );

    modport slave (
        input  res_valid, res_data, frame_len, user_r_read_32_rden, user_r_read_32_open,
        output res_ready, user_r_read_32_data, user_r_read_32_empty, user_r_read_32_eof,
               words_sent
    );
endinterface

// File: rtl/read_32_stream_source_fifo.sv
// Single-clock FIFO with registered read data, count and flags; no fall-through.
module sync_fifo_fwft_n #(
    parameter int unsigned DEPTH_LOG2 = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  wr_en_i,
    input  logic [31:0]           wr_data_i,
    input  logic                  rd_en_i,
    output logic [31:0]           rd_data_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  full_o,
    output logic                  empty_o
);
    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  full_q, empty_q, empty_d, full_d;
    logic [31:0]           data_q;
    logic                  wr_ok, rd_ok;

    assign wr_ok = wr_en_i && !full_q;
    assign rd_ok = rd_en_i && !empty_q;

    // empty only clears once the word has sat in memory for a full cycle,
    // but sets on the same edge as the read that drains the last word.
    always_comb begin
        count_d = count_q;
        if (wr_ok && !rd_ok)
            count_d = count_q + 1'b1;
        else if (rd_ok && !wr_ok)
            count_d = count_q - 1'b1;
        empty_d = (count_d == '0) || (count_q == '0);
        full_d  = (count_d == (DEPTH_LOG2+1)'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            data_q   <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            data_q   <= '0;
        end else begin
            if (wr_ok)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                data_q   <= mem[rd_ptr_q];
            end
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = data_q;
    assign count_o   = count_q;
    assign full_o    = full_q;
    assign empty_o   = empty_q;
endmodule

// File: rtl/read_32_stream_source.sv
// User-side source for the Xillybus 32-bit read stream with per-frame EOF.
// Optional READ32_PIXEL_CLAMP_EN inserts a [0,255] clamp register before the FIFO.
module read_32_stream_source
    import read_stream_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int unsigned LEN_W      = LEN_W_DEF
) (
    input  logic                    bus_clk,
    input  logic                    bus_rst_n,
    read_32_stream_source_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    st_e              state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d, acc_q, acc_d, sent_q, sent_d;

    logic                  flush, ready, xfer, rd_ok;
    logic                  fifo_wr, fifo_full, fifo_empty;
    logic [31:0]           fifo_wdata, fifo_rdata;
    logic [DEPTH_LOG2:0]   fifo_count;
    logic [DEPTH_LOG2+1:0] occ;

    assign flush = (state_q == IDLE) || !bus.user_r_read_32_open;
    assign rd_ok = bus.user_r_read_32_rden && !fifo_empty;
    assign ready = (state_q == STREAM) && !fifo_full
                && (occ < (DEPTH_LOG2+2)'(DEPTH))
                && ((len_q == '0) || (acc_q < len_q));
    assign xfer  = bus.res_valid && ready;

`ifdef READ32_PIXEL_CLAMP_EN
    logic        stage_v_q;
    logic [31:0] stage_q;

    // The staged word is already committed, so it counts against FIFO space.
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            stage_v_q <= 1'b0;
            stage_q   <= '0;
        end else if (flush) begin
            stage_v_q <= 1'b0;
            stage_q   <= '0;
        end else begin
            stage_v_q <= xfer;
            if (xfer)
                stage_q <= clamp_pix(bus.res_data);
        end
    end

    assign fifo_wr    = stage_v_q;
    assign fifo_wdata = stage_q;
    assign occ        = {1'b0, fifo_count} + {{(DEPTH_LOG2+1){1'b0}}, stage_v_q};
`else
    assign fifo_wr    = xfer;
    assign fifo_wdata = bus.res_data;
    assign occ        = {1'b0, fifo_count};
`endif

    sync_fifo_fwft_n #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk       (bus_clk),
        .rst_n     (bus_rst_n),
        .flush_i   (flush),
        .wr_en_i   (fifo_wr),
        .wr_data_i (fifo_wdata),
        .rd_en_i   (bus.user_r_read_32_rden),
        .rd_data_o (fifo_rdata),
        .count_o   (fifo_count),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        acc_d   = acc_q;
        sent_d  = sent_q;
        if (!bus.user_r_read_32_open) begin
            state_d = IDLE;
            len_d   = '0;
            acc_d   = '0;
            sent_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = STREAM;
                    len_d   = bus.frame_len;
                    acc_d   = '0;
                    sent_d  = '0;
                end
                STREAM: begin
                    if (xfer && (acc_q != '1))
                        acc_d = acc_q + 1'b1;
                    if (rd_ok) begin
                        if (sent_q != '1)
                            sent_d = sent_q + 1'b1;
                        if ((len_q != '0) && (LEN_W'(sent_q + 1'b1) == len_q))
                            state_d = DONE;
                    end
                end
                DONE: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            acc_q   <= '0;
            sent_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            acc_q   <= acc_d;
            sent_q  <= sent_d;
        end
    end

    assign bus.res_ready            = ready;
    assign bus.user_r_read_32_data  = fifo_rdata;
    assign bus.user_r_read_32_empty = fifo_empty;
    assign bus.user_r_read_32_eof   = (state_q == DONE);
    assign bus.words_sent           = sent_q;
endmodule

// File: tb/tb_read_32_stream_source.sv
// Directed self-checking bench for read_32_stream_source (FIFO depth 8).
module tb_read_32_stream_source;
    localparam int unsigned LEN_W = 16;

    logic bus_clk = 1'b0;
    logic bus_rst_n;
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    read_32_stream_source_if #(.LEN_W(LEN_W)) bus ();

    read_32_stream_source #(
        .DEPTH_LOG2 (3),
        .LEN_W      (LEN_W)
    ) dut (
        .bus_clk   (bus_clk),
        .bus_rst_n (bus_rst_n),
        .bus       (bus)
    );

    always #5 bus_clk = ~bus_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge bus_clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        int unsigned t;
        bus.res_valid = 1'b1;
        bus.res_data  = d;
        t = 0;
        while (!bus.res_ready && t < 40) begin
            tick();
            t++;
        end
        if (!bus.res_ready) check("push_timeout", 32'(bus.res_ready), 32'd1);
        tick();
        bus.res_valid = 1'b0;
    endtask

    task automatic read_word(input string tag, input logic [31:0] exp);
        int unsigned t;
        t = 0;
        while (bus.user_r_read_32_empty && t < 40) begin
            tick();
            t++;
        end
        if (bus.user_r_read_32_empty) check("read_timeout", 32'(bus.user_r_read_32_empty), 32'd0);
        bus.user_r_read_32_rden = 1'b1;
        tick();
        bus.user_r_read_32_rden = 1'b0;
        check(tag, bus.user_r_read_32_data, exp);
    endtask

    task automatic open_frame(input logic [LEN_W-1:0] len);
        bus.frame_len           = len;
        bus.user_r_read_32_open = 1'b1;
        tick();
    endtask

    task automatic close_frame();
        bus.user_r_read_32_open = 1'b0;
        tick();
    endtask

    initial begin
        logic [31:0] cexp [3];
        bus.res_valid           = 1'b0;
        bus.res_data            = '0;
        bus.frame_len           = '0;
        bus.user_r_read_32_rden = 1'b0;
        bus.user_r_read_32_open = 1'b0;
        bus_rst_n               = 1'b0;
        repeat (3) tick();
        bus_rst_n = 1'b1;
        tick();

        check("rst_ready", 32'(bus.res_ready), 32'd0);
        check("rst_empty", 32'(bus.user_r_read_32_empty), 32'd1);
        check("rst_eof",   32'(bus.user_r_read_32_eof), 32'd0);
        check("rst_data",  bus.user_r_read_32_data, 32'h0);
        check("rst_sent",  32'(bus.words_sent), 32'd0);

        // Basic frame of four words.
        open_frame(16'd4);
        check("bf_ready", 32'(bus.res_ready), 32'd1);
        push(32'h11); push(32'h22); push(32'h33); push(32'h44);
        check("bf_ready_lim", 32'(bus.res_ready), 32'd0);
        read_word("bf_d0", 32'h11);
        check("bf_eof_mid", 32'(bus.user_r_read_32_eof), 32'd0);
        read_word("bf_d1", 32'h22);
        read_word("bf_d2", 32'h33);
        read_word("bf_d3", 32'h44);
        check("bf_empty", 32'(bus.user_r_read_32_empty), 32'd1);
        check("bf_eof",   32'(bus.user_r_read_32_eof), 32'd1);
        check("bf_sent",  32'(bus.words_sent), 32'd4);
        tick();
        check("bf_eof_hold", 32'(bus.user_r_read_32_eof), 32'd1);
        close_frame();
        check("bf_eof_drop", 32'(bus.user_r_read_32_eof), 32'd0);
        check("bf_sent_clr", 32'(bus.words_sent), 32'd0);

        // Unbounded frame filling the 8-deep FIFO.
        open_frame(16'd0);
        for (int i = 0; i < 8; i++) push(32'h50 + 32'(i));
        check("bp_full_ready", 32'(bus.res_ready), 32'd0);
        bus.res_valid = 1'b1;
        bus.res_data  = 32'h58;
        tick();
        check("bp_held", 32'(bus.res_ready), 32'd0);
        read_word("bp_d0", 32'h50);
        check("bp_ready_again", 32'(bus.res_ready), 32'd1);
        tick();
        bus.res_valid = 1'b0;
        check("bp_full_again", 32'(bus.res_ready), 32'd0);
        for (int i = 1; i < 9; i++) read_word("bp_dn", 32'h50 + 32'(i));
        check("bp_sent", 32'(bus.words_sent), 32'd9);
        check("bp_no_eof", 32'(bus.user_r_read_32_eof), 32'd0);
        close_frame();

        // Words beyond frame length stay back-pressured.
        open_frame(16'd2);
        push(32'hA1); push(32'hA2);
        bus.res_valid = 1'b1;
        bus.res_data  = 32'hA3;
        check("ex_ready0", 32'(bus.res_ready), 32'd0);
        tick();
        check("ex_ready1", 32'(bus.res_ready), 32'd0);
        read_word("ex_d0", 32'hA1);
        read_word("ex_d1", 32'hA2);
        check("ex_eof",   32'(bus.user_r_read_32_eof), 32'd1);
        check("ex_empty", 32'(bus.user_r_read_32_empty), 32'd1);
        repeat (3) tick();
        check("ex_still_empty", 32'(bus.user_r_read_32_empty), 32'd1);
        check("ex_sent", 32'(bus.words_sent), 32'd2);
        bus.res_valid = 1'b0;
        close_frame();

        // Close in the middle of a frame, then reopen.
        open_frame(16'd8);
        for (int i = 0; i < 5; i++) push(32'hC0 + 32'(i));
        read_word("cm_d0", 32'hC0);
        read_word("cm_d1", 32'hC1);
        close_frame();
        check("cm_empty", 32'(bus.user_r_read_32_empty), 32'd1);
        check("cm_sent",  32'(bus.words_sent), 32'd0);
        check("cm_data",  bus.user_r_read_32_data, 32'h0);
        open_frame(16'd1);
        repeat (3) tick();
        check("cm_flushed", 32'(bus.user_r_read_32_empty), 32'd1);
        push(32'hAB);
        read_word("cm_ab", 32'hAB);
        check("cm_eof", 32'(bus.user_r_read_32_eof), 32'd1);
        close_frame();

        // Asynchronous reset between edges.
        open_frame(16'd0);
        push(32'h61); push(32'h62);
        tick(); tick();
        check("ar_pre_empty", 32'(bus.user_r_read_32_empty), 32'd0);
        read_word("ar_d0", 32'h61);
        #2;
        bus_rst_n = 1'b0;
        #1;
        check("ar_empty", 32'(bus.user_r_read_32_empty), 32'd1);
        check("ar_ready", 32'(bus.res_ready), 32'd0);
        check("ar_data",  bus.user_r_read_32_data, 32'h0);
        check("ar_sent",  32'(bus.words_sent), 32'd0);
        check("ar_eof",   32'(bus.user_r_read_32_eof), 32'd0);
        #3;
        bus_rst_n = 1'b1;
        tick();
        bus.user_r_read_32_rden = 1'b1;
        tick();
        bus.user_r_read_32_rden = 1'b0;
        check("ar_rden_data",  bus.user_r_read_32_data, 32'h0);
        check("ar_rden_sent",  32'(bus.words_sent), 32'd0);
        check("ar_rden_empty", 32'(bus.user_r_read_32_empty), 32'd1);
        close_frame();

        // Signed inputs around the pixel range.
`ifdef READ32_PIXEL_CLAMP_EN
        cexp[0] = 32'h0;        cexp[1] = 32'hFF;  cexp[2] = 32'h80;
`else
        cexp[0] = 32'hFFFFFFFB; cexp[1] = 32'h12C; cexp[2] = 32'h80;
`endif
        open_frame(16'd3);
        push(32'hFFFFFFFB); push(32'd300); push(32'd128);
        read_word("cl_d0", cexp[0]);
        read_word("cl_d1", cexp[1]);
        read_word("cl_d2", cexp[2]);
        check("cl_eof", 32'(bus.user_r_read_32_eof), 32'd1);
        close_frame();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
